// File: rtl/wd_pkg.sv
// Shared constants for the windowed-watchdog supervisor: state encoding and
// default widths/lengths.
package wd_pkg;

  localparam int TW_DEF     = 16;
  localparam int FW_DEF     = 4;
  localparam int RSTLEN_DEF = 16;

  typedef logic [2:0] wd_state_t;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_PULSE  = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_CLOSED = 3'd3;
  localparam logic [2:0] ST_OPEN   = 3'd4;
  localparam logic [2:0] ST_RSTOUT = 3'd5;

endpackage

// File: rtl/wd_edge_detect.sv
// Rising-edge detector for the software kick level. The history register
// resets to 1 so a level already high at reset release is not seen as an edge.
module wd_edge_detect (
  input  logic CLK,
  input  logic RSTN,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      din_q <= 1'b1;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/wd_supervisor.sv
// Windowed-watchdog supervisor: restarts service_window via INIT, classifies
// kicks against SWSTAT, counts faults and raises WDRST at the fault limit.
module wd_supervisor
  import wd_pkg::*;
#(
  parameter int TW     = TW_DEF,
  parameter int FW     = FW_DEF,
  parameter int RSTLEN = RSTLEN_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          KICK,
  input  logic          SWSTAT,
  input  logic [TW-1:0] TOLEN,
  input  logic [FW-1:0] MAXFAULT,
  output logic          INIT,
  output logic          WDRST,
  output logic [FW-1:0] FAULTCNT,
  output logic          EARLY,
  output logic          TIMEOUT,
  output logic [2:0]    STATE
);

  // KICK is a synchronous level with no handshake: only its rising edge is an
  // event, and it is consumed only in CLOSED (early) or OPEN (valid).
  // SWSTAT is trusted only from CLOSED onward; GUARD masks its settling.
  logic kick_rise;

  wd_edge_detect u_kick_edge (
    .CLK  (CLK),
    .RSTN (RSTN),
    .din  (KICK),
    .rise (kick_rise)
  );

  wd_state_t     state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [FW-1:0] fault_q,   fault_d;
  logic          init_q,    init_d;
  logic          wdrst_q,   wdrst_d;
  logic          early_q,   early_d;
  logic          timeout_q, timeout_d;

  logic          fault_hit;
  logic [FW-1:0] fault_limit;
  logic [FW:0]   fault_inc;

  assign fault_limit = (MAXFAULT == '0) ? FW'(1) : MAXFAULT;
  assign fault_inc   = {1'b0, fault_q} + {{FW{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    fault_d   = fault_q;
    wdrst_d   = wdrst_q;
    early_d   = 1'b0;
    timeout_d = 1'b0;
    fault_hit = 1'b0;

    case (state_q)
      ST_BOOT:  state_d = ST_PULSE;
      ST_PULSE: state_d = ST_GUARD;
      ST_GUARD: state_d = ST_CLOSED;
      ST_CLOSED: begin
        // A kick in the same cycle SWSTAT rises is still early.
        if (kick_rise) begin
          early_d   = 1'b1;
          fault_hit = 1'b1;
        end else if (SWSTAT) begin
          timer_d = '0;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        // A kick wins over a timeout landing in the same cycle.
        if (kick_rise) begin
          fault_d = (fault_q == '0) ? '0 : fault_q - FW'(1);
          state_d = ST_PULSE;
        end else if (timer_q == TOLEN) begin
          timeout_d = 1'b1;
          fault_hit = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RSTOUT: begin
        if (timer_q == TW'(RSTLEN - 1)) begin
          wdrst_d = 1'b0;
          fault_d = '0;
          state_d = ST_PULSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (fault_hit) begin
      fault_d = fault_inc[FW] ? {FW{1'b1}} : fault_inc[FW-1:0];
      if (fault_inc >= {1'b0, fault_limit}) begin
        state_d = ST_RSTOUT;
        wdrst_d = 1'b1;
        timer_d = '0;
      end else begin
        state_d = ST_PULSE;
      end
    end

    // INIT is registered off the next state so it is low exactly while in PULSE.
    init_d = (state_d != ST_PULSE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_BOOT;
      timer_q   <= '0;
      fault_q   <= '0;
      init_q    <= 1'b1;
      wdrst_q   <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fault_q   <= fault_d;
      init_q    <= init_d;
      wdrst_q   <= wdrst_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign INIT     = init_q;
  assign WDRST    = wdrst_q;
  assign FAULTCNT = fault_q;
  assign EARLY    = early_q;
  assign TIMEOUT  = timeout_q;
  assign STATE    = state_q;

endmodule

// File: doc/wd_supervisor.md
Name: wd_supervisor

Overview:
- Windowed-watchdog supervisor; sits directly upstream of service_window.
- Drives service_window INIT and consumes its SWSTAT.
- Classifies each software KICK as valid, early or late. Counts faults and issues a system reset request once the fault limit is reached.
- SWSTAT=0 means the window is closed and a kick is early. SWSTAT=1 means the window is open and kicks are allowed.

Parameters:
- TW, 16, width of TOLEN and of the open-window timer
- FW, 4, width of MAXFAULT and FAULTCNT
- RSTLEN, 16, number of cycles WDRST is held high

Ports:
- CLK  in  1  system clock, all logic on posedge
- RSTN  in  1  reset, asynchronous, active-low
- KICK  in  1  service request from software, synchronous level; its rising edge is a kick
- SWSTAT  in  1  window status from service_window
- TOLEN  in  TW  open-window timeout length in cycles
- MAXFAULT  in  FW  fault limit; 0 is treated as 1
- INIT  out  1  active-low restart pulse to service_window
- WDRST  out  1  system reset request
- FAULTCNT  out  FW  current fault count
- EARLY  out  1  one-cycle pulse for an early-kick fault
- TIMEOUT  out  1  one-cycle pulse for a missed-kick fault
- STATE  out  3  encoded FSM state, for debug

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RSTN).
- All outputs are registered.
- Reset values: INIT=1, WDRST=0, FAULTCNT=0, EARLY=0, TIMEOUT=0, STATE=BOOT, timer=0, kick_q=1.
  - kick_q=1 at reset means a KICK already high at reset release is not counted as a kick.
- kick_rise = KICK & ~kick_q; kick_q is updated every cycle.
- States: BOOT=0, PULSE=1, GUARD=2, CLOSED=3, OPEN=4, RSTOUT=5.
- BOOT: leave after one cycle -> PULSE. service_window reacts only to a falling INIT edge, so this first pulse is mandatory.
- PULSE: INIT=0 for exactly one cycle -> GUARD.
- GUARD: INIT=1. SWSTAT and kicks are ignored for one cycle because service_window updates SWSTAT asynchronously. -> CLOSED.
- CLOSED:
  - If kick_rise: EARLY=1 for one cycle, fault increment, -> PULSE.
  - Otherwise, if SWSTAT=1: timer=0, -> OPEN.
  - A kick in the same cycle that SWSTAT rises is early.
- OPEN:
  - If kick_rise: valid kick; FAULTCNT decrements by 1, saturating at 0; -> PULSE.
  - Otherwise, if timer==TOLEN: TIMEOUT=1 for one cycle, fault increment, -> PULSE.
  - Otherwise timer++.
  - A kick in the same cycle as timeout counts as valid.
  - The timeout fires on the (TOLEN+1)th cycle in OPEN.
- Fault increment:
  - If FAULTCNT+1 >= max(MAXFAULT,1): -> RSTOUT instead of PULSE. FAULTCNT is set to that incremented value and saturates at all-ones.
- RSTOUT:
  - WDRST=1 for RSTLEN cycles and kicks are ignored.
  - On exit: WDRST=0, FAULTCNT=0, -> PULSE.
- Kicks are ignored in BOOT, PULSE, GUARD and RSTOUT; kick_q still tracks KICK.
- TOLEN and MAXFAULT are sampled live; a change takes effect at the next compare.
- RSTN asserted mid-operation: everything returns to reset values immediately, with INIT forced to 1 asynchronously. The sequence restarts at BOOT on release.

Decomposition:
- Package wd_pkg: state encoding constants (BOOT..RSTOUT), default RSTLEN, FW, TW.
- Sub-module wd_edge_detect: kick_q register with reset-to-1 and the rising-edge output.
- The FSM, timer and fault counter stay in wd_supervisor.

Test Plan:
- Reset release (bench with service_window, SWLEN=10, TOLEN=20, MAXFAULT=3):
  - INIT is low for exactly one cycle, 2 cycles after RSTN rises.
  - SWSTAT rises 10 cycles later and STATE reaches OPEN=4.
- Valid kick 5 cycles into OPEN:
  - INIT pulse on the next cycle; no EARLY, no TIMEOUT; FAULTCNT stays 0.
- Kick 3 cycles into CLOSED:
  - EARLY pulse, FAULTCNT=1, INIT re-pulses.
  - A later valid kick returns FAULTCNT to 0.
- No kick while OPEN:
  - TIMEOUT pulses on the 21st OPEN cycle and FAULTCNT=1.
  - A kick exactly on the 21st OPEN cycle instead gives no TIMEOUT and FAULTCNT stays 0.
- Three consecutive timeouts:
  - On the third fault, WDRST=1 for 16 cycles.
  - Then FAULTCNT=0 and an INIT pulse follows.
- KICK held high through reset release, and RSTN dropped while in OPEN:
  - No kick is counted.
  - All outputs return to reset values immediately and BOOT restarts.
